// File: rtl/rv_sim_mem_if.sv
// rv_sim_mem_if: fetch, data, backdoor and exit-status
// signals between the core/harness and rv_sim_mem.
interface rv_sim_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  instr_req;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [31:0]           instr_data;
  logic                  instr_valid;
  logic                  mem_re;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_rdata;
  logic                  mem_ready;
  logic                  bd_we;
  logic [ADDR_WIDTH-1:0] bd_addr;
  logic [31:0]           bd_wdata;
  logic                  done;
  logic [31:0]           exit_code;
  logic                  addr_err;

  modport master (
    output instr_req, instr_addr,
    output mem_re, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    output bd_we, bd_addr, bd_wdata,
    input  instr_data, instr_valid,
    input  mem_rdata, mem_ready,
    input  done, exit_code, addr_err
  );

  modport slave (
    input  instr_req, instr_addr,
    input  mem_re, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    input  bd_we, bd_addr, bd_wdata,
    output instr_data, instr_valid,
    output mem_rdata, mem_ready,
    output done, exit_code, addr_err
  );
endinterface

// File: rtl/rv_sim_mem.sv
// rv_sim_mem: latency-modelled word memory with tohost exit.
// Option macro RV_SIM_MEM_RAND_STALL_EN adds LFSR data stalls.
module rv_sim_mem #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DEPTH_WORDS   = 4096,
  parameter int          INSTR_LATENCY = 1,
  parameter int          DATA_LATENCY  = 2,
  parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000
) (
  input logic         clk,
  input logic         rst,
  rv_sim_mem_if.slave bus
);
  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE, WAIT, RESP
  } state_t;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  logic [31:0] r_mem [DEPTH_WORDS];

  function automatic logic f_host(addr_t a);
    return (a >> 2) == (addr_t'(TOHOST_ADDR) >> 2);
  endfunction

  function automatic logic f_in(addr_t a);
    return (a >> 2) < addr_t'(DEPTH_WORDS);
  endfunction

  function automatic logic [IW-1:0] f_idx(addr_t a);
    return IW'(a >> 2);
  endfunction

  state_t      r_i_st;
  logic [4:0]  r_i_cnt;
  addr_t       r_i_addr;
  logic        r_i_valid;
  logic [31:0] r_i_data;

  state_t      r_d_st;
  logic [4:0]  r_d_cnt;
  addr_t       r_d_addr;
  logic        r_d_we;
  logic [31:0] r_d_wdata;
  logic [3:0]  r_d_strb;
  logic        r_d_ready;
  logic [31:0] r_d_rdata;

  logic        r_done;
  logic [31:0] r_exit;
  logic        r_err;

  addr_t       w_i_addr;
  logic        w_i_go;
  logic        w_i_host;
  logic        w_i_oob;
  logic [31:0] w_i_rd;

  addr_t       w_d_addr;
  logic        w_d_req;
  logic        w_d_we;
  logic [31:0] w_d_wdata;
  logic [3:0]  w_d_strb;
  logic [4:0]  w_d_lat;
  logic        w_d_go;
  logic        w_d_host;
  logic        w_d_oob;
  logic [31:0] w_d_rd;

  logic        w_bd_ok;

`ifdef RV_SIM_MEM_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running stall source, restarted by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13] ^
                 r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_d_lat = 5'(DATA_LATENCY)
                 + {3'b000, r_lfsr[1:0]};
`else
  assign w_d_lat = 5'(DATA_LATENCY);
`endif

  // In IDLE the response may fire on the accept edge,
  // so the live request fields are used there.
  assign w_i_addr = (r_i_st == IDLE) ?
                    bus.instr_addr : r_i_addr;
  assign w_i_go   = !rst &&
    ((r_i_st == IDLE && bus.instr_req &&
      INSTR_LATENCY == 1) ||
     (r_i_st == WAIT && r_i_cnt == 5'd1));
  assign w_i_host = f_host(w_i_addr);
  assign w_i_oob  = !w_i_host && !f_in(w_i_addr);

  assign w_d_req   = bus.mem_re | bus.mem_we;
  assign w_d_addr  = (r_d_st == IDLE) ?
                     bus.mem_addr : r_d_addr;
  assign w_d_we    = (r_d_st == IDLE) ?
                     bus.mem_we : r_d_we;
  assign w_d_wdata = (r_d_st == IDLE) ?
                     bus.mem_wdata : r_d_wdata;
  assign w_d_strb  = (r_d_st == IDLE) ?
                     bus.mem_wstrb : r_d_strb;
  assign w_d_go    = !rst &&
    ((r_d_st == IDLE && w_d_req &&
      w_d_lat == 5'd1) ||
     (r_d_st == WAIT && r_d_cnt == 5'd1));
  assign w_d_host  = f_host(w_d_addr);
  assign w_d_oob   = !w_d_host && !f_in(w_d_addr);

  assign w_bd_ok = bus.bd_we &&
                   !f_host(bus.bd_addr) &&
                   f_in(bus.bd_addr);

  // Fetch read value: exit register, storage or zero.
  always_comb begin
    w_i_rd = '0;
    if (w_i_host) begin
      w_i_rd = r_exit;
    end else if (!w_i_oob) begin
      w_i_rd = r_mem[f_idx(w_i_addr)];
    end
  end

  // Data read value, taken before any same-edge write.
  always_comb begin
    w_d_rd = '0;
    if (w_d_host) begin
      w_d_rd = r_exit;
    end else if (!w_d_oob) begin
      w_d_rd = r_mem[f_idx(w_d_addr)];
    end
  end

  // Backing store; backdoor is last so it wins a tie.
  always_ff @(posedge clk) begin
    if (w_d_go && w_d_we && !w_d_host && !w_d_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (w_d_strb[b]) begin
          r_mem[f_idx(w_d_addr)][8*b +: 8] <=
            w_d_wdata[8*b +: 8];
        end
      end
    end
    if (w_bd_ok) begin
      r_mem[f_idx(bus.bd_addr)] <= bus.bd_wdata;
    end
  end

  // Instruction port FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_st    <= IDLE;
      r_i_cnt   <= '0;
      r_i_addr  <= '0;
      r_i_valid <= 1'b0;
      r_i_data  <= '0;
    end else begin
      r_i_valid <= 1'b0;
      unique case (r_i_st)
        IDLE: begin
          if (bus.instr_req) begin
            r_i_addr <= bus.instr_addr;
            r_i_cnt  <= 5'(INSTR_LATENCY - 1);
            r_i_st   <= (INSTR_LATENCY == 1) ?
                        RESP : WAIT;
          end
        end
        WAIT: begin
          r_i_cnt <= r_i_cnt - 5'd1;
          if (r_i_cnt == 5'd1) r_i_st <= RESP;
        end
        RESP: r_i_st <= IDLE;
        default: r_i_st <= IDLE;
      endcase
      if (w_i_go) begin
        r_i_valid <= 1'b1;
        r_i_data  <= w_i_rd;
      end
    end
  end

  // Data port FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_st    <= IDLE;
      r_d_cnt   <= '0;
      r_d_addr  <= '0;
      r_d_we    <= 1'b0;
      r_d_wdata <= '0;
      r_d_strb  <= '0;
      r_d_ready <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_d_ready <= 1'b0;
      unique case (r_d_st)
        IDLE: begin
          if (w_d_req) begin
            r_d_addr  <= bus.mem_addr;
            r_d_we    <= bus.mem_we;
            r_d_wdata <= bus.mem_wdata;
            r_d_strb  <= bus.mem_wstrb;
            r_d_cnt   <= w_d_lat - 5'd1;
            r_d_st    <= (w_d_lat == 5'd1) ?
                         RESP : WAIT;
          end
        end
        WAIT: begin
          r_d_cnt <= r_d_cnt - 5'd1;
          if (r_d_cnt == 5'd1) r_d_st <= RESP;
        end
        RESP: r_d_st <= IDLE;
        default: r_d_st <= IDLE;
      endcase
      if (w_d_go) begin
        r_d_ready <= 1'b1;
        r_d_rdata <= w_d_rd;
      end
    end
  end

  // Sticky exit and out-of-range status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_exit <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_i_go && w_i_oob) r_err <= 1'b1;
      if (w_d_go && w_d_oob) r_err <= 1'b1;
      if (w_d_go && w_d_we && w_d_host) begin
        r_done <= 1'b1;
        r_exit <= w_d_wdata;
      end
    end
  end

  assign bus.instr_valid = r_i_valid;
  assign bus.instr_data  = r_i_data;
  assign bus.mem_ready   = r_d_ready;
  assign bus.mem_rdata   = r_d_rdata;
  assign bus.done        = r_done;
  assign bus.exit_code   = r_exit;
  assign bus.addr_err    = r_err;
endmodule

// File: tb/tb_rv_sim_mem.sv
// tb_rv_sim_mem: random traffic on both ports plus backdoor,
// checked each cycle against a cycle-numbered reference.
module tb_rv_sim_mem;
  localparam int          AW     = 32;
  localparam int          DEPTH  = 4096;
  localparam int          IL     = 1;
  localparam int          DL     = 2;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rv_sim_mem_if #(.ADDR_WIDTH(AW)) bus ();

  rv_sim_mem #(
    .ADDR_WIDTH   (AW),
    .DEPTH_WORDS  (DEPTH),
    .INSTR_LATENCY(IL),
    .DATA_LATENCY (DL),
    .TOHOST_ADDR  (TOHOST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mm [int unsigned];
  bit          armed = 0;
  int          cyc = 0;
  bit          ip = 0, dp = 0;
  int          idue = 0, ddue = 0, ifree = 0, dfree = 0;
  logic [31:0] ia = 0, da = 0, dwd = 0;
  logic [3:0]  dst = 0;
  bit          dwe = 0;
  int          m_x = 0;
  logic [31:0] m_ri = 0, m_rd = 0, m_w = 0;
  logic        e_iv = 0, e_dr = 0, e_done = 0, e_err = 0;
  logic [31:0] e_id = 0, e_dd = 0, e_exit = 0;
`ifdef RV_SIM_MEM_RAND_STALL_EN
  logic [15:0] mlfsr = 16'hACE1;
`endif

  function automatic bit is_host(input logic [31:0] a);
    return (a >> 2) == (TOHOST >> 2);
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return !is_host(a) && ((a >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (is_host(a)) return e_exit;
    if (is_oob(a)) return 32'h0;
    return mm.exists(k) ? mm[k] : 32'h0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      armed = 1;
      ip = 0; dp = 0;
      e_iv = 0; e_dr = 0; e_id = 0; e_dd = 0;
      e_done = 0; e_exit = 0; e_err = 0;
`ifdef RV_SIM_MEM_RAND_STALL_EN
      mlfsr = 16'hACE1;
`endif
    end else begin
      e_iv = 0; e_dr = 0; m_x = 0;
`ifdef RV_SIM_MEM_RAND_STALL_EN
      m_x = int'(mlfsr[1:0]);
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13]
               ^ mlfsr[12] ^ mlfsr[10]};
`endif
      if (!ip && cyc >= ifree && bus.instr_req) begin
        ip = 1; idue = cyc + IL - 1;
        ia = bus.instr_addr;
      end
      if (!dp && cyc >= dfree &&
          (bus.mem_re || bus.mem_we)) begin
        dp = 1; ddue = cyc + DL - 1 + m_x;
        da = bus.mem_addr; dwe = bus.mem_we;
        dwd = bus.mem_wdata; dst = bus.mem_wstrb;
      end
      m_ri = mread(ia);
      m_rd = mread(da);
      if (ip && idue == cyc) begin
        e_iv = 1; e_id = m_ri; ip = 0;
        ifree = cyc + 2;
        if (is_oob(ia)) e_err = 1;
      end
      if (dp && ddue == cyc) begin
        e_dr = 1; e_dd = m_rd; dp = 0;
        dfree = cyc + 2;
        if (is_oob(da)) e_err = 1;
        if (dwe && is_host(da)) begin
          e_done = 1; e_exit = dwd;
        end else if (dwe && !is_oob(da)) begin
          m_w = m_rd;
          for (int b = 0; b < 4; b++)
            if (dst[b]) m_w[8*b +: 8] = dwd[8*b +: 8];
          mm[da >> 2] = m_w;
        end
      end
    end
    if (bus.bd_we && !is_host(bus.bd_addr) &&
        !is_oob(bus.bd_addr))
      mm[bus.bd_addr >> 2] = bus.bd_wdata;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("instr_valid", 32'(bus.instr_valid), 32'(e_iv));
      chk("instr_data", bus.instr_data, e_id);
      chk("mem_ready", 32'(bus.mem_ready), 32'(e_dr));
      chk("mem_rdata", bus.mem_rdata, e_dd);
      chk("done", 32'(bus.done), 32'(e_done));
      chk("exit_code", bus.exit_code, e_exit);
      chk("addr_err", 32'(bus.addr_err), 32'(e_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ifetch(input logic [31:0] a,
                        output logic [31:0] d,
                        output int lat);
    bit got;
    got = 0; d = 0; lat = 0;
    @(negedge clk);
    bus.instr_req = 1; bus.instr_addr = a;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        got = 1; lat = i; d = bus.instr_data;
      end
    end
    bus.instr_req = 0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ifetch_timeout addr=%h", a);
    end
  endtask

  task automatic dacc(input bit re, input bit we,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0] st,
                      output logic [31:0] d,
                      output int lat);
    bit got;
    got = 0; d = 0; lat = 0;
    @(negedge clk);
    bus.mem_re = re; bus.mem_we = we;
    bus.mem_addr = a; bus.mem_wdata = wd;
    bus.mem_wstrb = st;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        got = 1; lat = i; d = bus.mem_rdata;
      end
    end
    bus.mem_re = 0; bus.mem_we = 0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL dacc_timeout addr=%h", a);
    end
  endtask

  function automatic logic [31:0] raddr(input bit hostok);
    int r;
    r = $urandom_range(0, 19);
    if (r < 16)
      return 32'(r * 4) | 32'($urandom_range(0, 3));
    if (r < 18 || !hostok)
      return 32'h4000 + 32'($urandom_range(0, 255) * 4);
    return TOHOST | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- main sequence ----------------
  logic [31:0] d;
  int          lat, n;
  bit          seen [32];

  initial begin
    bus.instr_req = 0; bus.instr_addr = 0;
    bus.mem_re = 0; bus.mem_we = 0; bus.mem_addr = 0;
    bus.mem_wdata = 0; bus.mem_wstrb = 0;
    bus.bd_we = 0; bus.bd_addr = 0; bus.bd_wdata = 0;

    // preload during reset
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      bus.bd_we = 1; bus.bd_addr = 32'(w * 4);
      bus.bd_wdata = (w == 0) ? 32'h0000_0013 :
                     (w == 4) ? 32'h0 : $urandom;
    end
    @(negedge clk);
    bus.bd_we = 0; rst = 0;
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_exit", bus.exit_code, 32'h0);
    chk("rst_err", 32'(bus.addr_err), 32'h0);
    chk("rst_ivalid", 32'(bus.instr_valid), 32'h0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);

    ifetch(32'h0, d, lat);
    chk("fetch0_data", d, 32'h0000_0013);
    chk("fetch0_lat", 32'(lat), 32'd1);

    dacc(0, 1, 32'h10, 32'hDEAD_BEEF, 4'b0101, d, lat);
    chk("wr10_lat", 32'(lat), 32'd2);
    dacc(1, 0, 32'h10, 32'h0, 4'h0, d, lat);
    chk("rd10_data", d, 32'h00AD_00EF);
    chk("rd10_lat", 32'(lat), 32'd2);

    dacc(0, 1, TOHOST, 32'h1, 4'h0, d, lat);
    chk("host_done", 32'(bus.done), 32'h1);
    chk("host_exit", bus.exit_code, 32'h1);

    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("rst2_done", 32'(bus.done), 32'h0);
    chk("rst2_exit", bus.exit_code, 32'h0);
    ifetch(32'h0, d, lat);
    chk("kept_word0", d, 32'h0000_0013);

    dacc(1, 0, 32'h4000, 32'h0, 4'h0, d, lat);
    chk("oob_rdata", d, 32'h0);
    chk("oob_err", 32'(bus.addr_err), 32'h1);
    chk("oob_lat", 32'(lat), 32'd2);

    // reset while the data port is waiting
    @(negedge clk);
    bus.mem_re = 1; bus.mem_addr = 32'h10;
    @(negedge clk);
    rst = 1; bus.mem_re = 0;
    @(negedge clk);
    rst = 0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_ready) n++;
    end
    chk("rst_wait_noresp", 32'(n), 32'd0);
    dacc(1, 0, 32'h10, 32'h0, 4'h0, d, lat);
    chk("after_rst_data", d, 32'h00AD_00EF);
    chk("after_rst_lat", 32'(lat), 32'd2);

    // random concurrent traffic
    fork
      begin
        logic [31:0] id;
        int il;
        for (int i = 0; i < 60; i++) begin
          ifetch(raddr(1), id, il);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        logic [31:0] dd;
        int dlat, op;
        for (int i = 0; i < 60; i++) begin
          op = $urandom_range(0, 3);
          dacc(op != 2, op >= 2, raddr(1), $urandom,
               4'($urandom_range(0, 15)), dd, dlat);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(negedge clk);
          bus.bd_we = ($urandom_range(0, 2) == 0);
          bus.bd_addr = raddr(1);
          bus.bd_wdata = $urandom;
        end
        @(negedge clk);
        bus.bd_we = 0;
      end
    join

`ifdef RV_SIM_MEM_RAND_STALL_EN
    n = 0;
    for (int i = 0; i < 100; i++) begin
      dacc(1, 0, 32'($urandom_range(0, 15) * 4), 32'h0,
           4'h0, d, lat);
      checks++;
      if (lat < 2 || lat > 5) begin
        errors++;
        $display("FAIL stall_lat act=%0d exp=2..5", lat);
      end else if (!seen[lat]) begin
        seen[lat] = 1; n++;
      end
    end
    chk("stall_distinct", 32'(n >= 2), 32'h1);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rv_sim_mem.md
Name: rv_sim_mem

Overview:
Parametrised simulation memory model serving the RV32E core's instruction and data ports during cocotb runs. It replaces fixed testbench-driven instruction and data values with a word-addressed backing store that has configurable per-port latency, a byte-write strobe, and a backdoor preload port. It also decodes a "tohost" exit register so benches end on a core-signalled result. It sits between the core and the cocotb harness and is never synthesised.

Parameters:
ADDR_WIDTH, 32, byte-address width of both ports
DEPTH_WORDS, 4096, 32-bit words in the backing store; valid byte range is 0 to DEPTH_WORDS*4-1
INSTR_LATENCY, 1, cycles from instruction-request accept to instr_valid; legal range 1..15
DATA_LATENCY, 2, cycles from data-request accept to mem_ready; legal range 1..15
TOHOST_ADDR, 32'h0000_1000, byte address of the exit register; never backed by storage

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
instr_req  in  1  instruction fetch request
instr_addr  in  ADDR_WIDTH  fetch byte address
instr_data  out  32  fetched word
instr_valid  out  1  instr_data valid, 1-cycle pulse
mem_re  in  1  data read request
mem_we  in  1  data write request
mem_addr  in  ADDR_WIDTH  data byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte enables for writes
mem_rdata  out  32  read data
mem_ready  out  1  data access complete, 1-cycle pulse
bd_we  in  1  backdoor word write (cocotb preload)
bd_addr  in  ADDR_WIDTH  backdoor byte address
bd_wdata  in  32  backdoor data
done  out  1  sticky, set by a write to TOHOST_ADDR
exit_code  out  32  word written to TOHOST_ADDR
addr_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset: instr_valid=0, mem_ready=0, instr_data=0, mem_rdata=0, done=0, exit_code=0, addr_err=0. Both port FSMs go to IDLE. Pending requests are dropped and produce no response. Storage contents are preserved.
- Each port runs an independent FSM with states IDLE, WAIT, RESP.
- IDLE: a request is accepted when req is high (data: mem_re|mem_we). The FSM latches the address, wdata and wstrb, loads cnt with LATENCY-1, and moves to WAIT. If LATENCY=1, it goes straight to RESP.
- WAIT: cnt decrements each cycle. At 0 the FSM moves to RESP.
- RESP: valid/ready is high for exactly 1 cycle, then the FSM returns to IDLE. Requests presented in RESP are ignored; the core must hold them. Maximum throughput is therefore one access per LATENCY+1 cycles.
- Response timing: valid/ready asserts exactly LATENCY cycles after the accept edge.
- Read data is sampled from storage in the RESP cycle, not at accept.
- Writes commit in the RESP cycle, per byte lane, where mem_wstrb[i] writes bits 8i+7:8i.
- mem_re and mem_we both high is a write. mem_rdata returns the pre-write word.
- Word index is addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored.
- Out of range (index >= DEPTH_WORDS, excluding TOHOST_ADDR):
  - reads return 32'h0000_0000;
  - writes are dropped;
  - addr_err is set;
  - the handshake still completes normally.
- TOHOST_ADDR write commit: done=1 and exit_code=mem_wdata, ignoring wstrb. A later write overwrites exit_code. A read of TOHOST_ADDR returns exit_code.
- Same-cycle collisions on the same word:
  - data-write commit vs instruction read: the instruction read returns the old word.
  - bd_we vs data-write commit: bd_we wins.
- bd_we writes one full word immediately with no handshake, is legal during rst, and out-of-range bd writes are dropped without flagging.
- instr_data and mem_rdata hold their last value outside RESP.

Optional Feature:
- Macro: RV_SIM_MEM_RAND_STALL_EN.
- When defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on rst) advances every cycle;
  - on each data-port accept, lfsr[1:0] extra cycles (0..3) are added to DATA_LATENCY;
  - the instruction port is unaffected.
- When undefined: data latency is exactly DATA_LATENCY, and the LFSR is absent.

Test Plan:
- Preload via bd_we word 0 = 32'h00000013. Then instr_req with instr_addr=0 and INSTR_LATENCY=1: instr_valid is high exactly 1 cycle after accept, and instr_data=32'h00000013.
- mem_we with addr 0x10, wdata 32'hDEADBEEF, wstrb 4'b0101 over a preset 0. Then mem_re at 0x10: mem_rdata=32'h00AD00EF, and mem_ready comes 2 cycles after each accept (DATA_LATENCY=2).
- mem_we to 0x1000 with wdata 32'h1: done=1 and exit_code=1 after mem_ready. Then assert rst: done=0, exit_code=0, while word 0 is still 32'h00000013.
- Read at 0x4000 (DEPTH_WORDS=4096): mem_rdata=0, addr_err=1, mem_ready still pulses.
- Accept a read, assert rst during WAIT: no mem_ready pulse, FSM returns to IDLE, and the next request completes with normal latency.
- With RV_SIM_MEM_RAND_STALL_EN defined: 100 reads at DATA_LATENCY=2 each take 2..5 cycles, and at least two distinct latencies are observed.
